desired_drive_pipe: RTL and testbench
=====================================

DESIRED_DRIVE_PIPE -- requirements
Module: desired_drive_pipe

Interface
REQ-001 SHALL have parameter TQ_W, default 12, avg_torque width.
REQ-002 SHALL have parameter INC_W, default 13, signed incline width.
REQ-003 SHALL have parameter CUR_W, default 12, target current width.
REQ-004 SHALL have parameter TORQUE_MIN, default 12'h380, torque dead-band offset.
REQ-005 SHALL have parameter SHIFT, default 15, product right-shift.
REQ-006 SHALL have parameter SLEW_STEP, default 12'h100, maximum output change per accepted sample.
REQ-007 clk  input  1  system clock; all state changes on its rising edge.
REQ-008 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-009 vld_in  input  1  sample-valid qualifier for all data inputs.
REQ-010 avg_torque  input  TQ_W  unsigned averaged pedal torque.
REQ-011 cadence  input  5  unsigned cadence.
REQ-012 incline  input  INC_W  signed (two's complement) incline.
REQ-013 scale  input  3  unsigned assist level, 0 = no assist.
REQ-014 not_pedaling  input  1  forces zero target for that sample.
REQ-015 vld_out  output  1  one-cycle pulse, target_curr updated this cycle.
REQ-016 target_curr  output  CUR_W  registered motor current target.
REQ-017 sat  output  1  registered; 1 when last accepted sample's shifted product saturated.

Function
REQ-018 SHALL accept a sample on every clk edge with vld_in=1; no backpressure; vld_in=0 inserts a bubble.
REQ-019 Stage 1 SHALL register: torque_pos = avg_torque-TORQUE_MIN, clipped to 0 if negative; incline_sat = incline saturated to 10-bit signed [-512..511]; incline_factor = incline_sat+256, clipped to [0..511] (9 bits); cadence_factor = (cadence>1) ? cadence+32 : 0 (6 bits).
REQ-020 Stage 2 SHALL register p_a = torque_pos*incline_factor and p_b = cadence_factor*scale, full width.
REQ-021 Stage 3 SHALL compute q = (p_a*p_b)>>SHIFT; raw = all-ones if q >= 2^CUR_W (sat=1) else q[CUR_W-1:0] (sat=0).
REQ-022 not_pedaling=1 SHALL force raw=0 and sat=0 for that sample, carried down the pipeline with the sample.
REQ-023 vld_out SHALL pulse exactly 3 clk cycles after the accepting edge; bubbles propagate; back-to-back samples give back-to-back pulses.
REQ-024 target_curr and sat SHALL hold their value on cycles without vld_out.
REQ-025 Samples SHALL be independent; no inter-sample state except the slew register (REQ-030).

Reset
REQ-026 rst_n low SHALL asynchronously clear all pipeline registers, valid bits, target_curr=0, sat=0, vld_out=0.
REQ-027 Samples in flight at reset SHALL be discarded; no vld_out from them after rst_n rises.
REQ-028 First sample accepted on the first edge after rst_n rises SHALL behave per REQ-023.

Configuration
REQ-029 Macro DRIVE_SLEW_EN SHALL select output slew limiting.
REQ-030 With DRIVE_SLEW_EN defined, on each vld_out target_curr SHALL move toward raw by min(|raw-target_curr|, SLEW_STEP); equal values leave it unchanged; no wrap; sat reflects raw.
REQ-031 Without DRIVE_SLEW_EN, on each vld_out target_curr SHALL equal raw; SLEW_STEP unused.

Verification
REQ-032 Slew off: avg_torque=800h, cadence=10h, incline=0150h, scale=3 -> vld_out 3 cycles later, target_curr=A1Ah, sat=0.
REQ-033 Slew off: avg_torque=800h, cadence=10h, incline=1F22h, scale=5 -> 11Eh; then avg_torque=360h -> 000h.
REQ-034 Slew off: avg_torque=7E0h, cadence=18h, scale=7, incline=0000h -> D66h; incline=0080h -> FFFh with sat=1; same with not_pedaling=1 -> 000h, sat=0.
REQ-035 Back-to-back samples A1Ah, 11Eh, D66h with one bubble between 2nd and 3rd -> vld_out pattern 1,1,0,1 with matching values in order.
REQ-036 Slew on: from reset, D66h target held on consecutive samples -> 100h, 200h, ..., D00h, D66h; then not_pedaling -> decreases by 100h per sample to 000h.
REQ-037 rst_n pulsed low with 2 samples in flight -> outputs 0 immediately, no vld_out for those samples.

Source files
------------

// File: rtl/desired_drive_pipe.sv
// rtl/desired_drive_pipe.sv - pipelined torque/incline/cadence to motor current target
// Output slew limiting is compiled in when DRIVE_SLEW_EN is defined.
module desired_drive_pipe #(
    parameter int               TQ_W       = 12,
    parameter int               INC_W      = 13,
    parameter int               CUR_W      = 12,
    parameter logic [TQ_W-1:0]  TORQUE_MIN = 12'h380,
    parameter int               SHIFT      = 15,
    parameter logic [CUR_W-1:0] SLEW_STEP  = 12'h100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld_in,
    input  logic [TQ_W-1:0]  avg_torque,
    input  logic [4:0]       cadence,
    input  logic [INC_W-1:0] incline,
    input  logic [2:0]       scale,
    input  logic             not_pedaling,
    output logic             vld_out,
    output logic [CUR_W-1:0] target_curr,
    output logic             sat
);

    localparam int PA_W   = TQ_W + 9;
    localparam int PB_W   = 9;
    localparam int PROD_W = PA_W + PB_W;
    localparam logic [PROD_W-1:0]      LP_Q_MAX  = PROD_W'({CUR_W{1'b1}});
    localparam logic signed [INC_W-1:0] LP_INC_HI = INC_W'(511);
    localparam logic signed [INC_W-1:0] LP_INC_LO = INC_W'(-512);

    logic [TQ_W:0]           w_tq_diff;
    logic [TQ_W-1:0]         w_tq_pos;
    logic signed [INC_W-1:0] w_inc_s;
    logic [9:0]              w_inc_sat;
    logic [10:0]             w_inc_sum;
    logic [8:0]              w_inc_fac;
    logic [5:0]              w_cad_fac;

    logic                    r_s1_vld;
    logic                    r_s1_np;
    logic [TQ_W-1:0]         r_s1_tq;
    logic [8:0]              r_s1_incf;
    logic [5:0]              r_s1_cadf;
    logic [2:0]              r_s1_scale;

    logic                    r_s2_vld;
    logic                    r_s2_np;
    logic [PA_W-1:0]         r_s2_pa;
    logic [PB_W-1:0]         r_s2_pb;

    logic [PROD_W-1:0]       w_prod;
    logic [PROD_W-1:0]       w_q;
    logic                    w_q_sat;
    logic [CUR_W-1:0]        w_raw;

    logic                    r_s3_vld;
    logic [CUR_W-1:0]        r_s3_raw;
    logic                    r_s3_sat;

    logic [CUR_W-1:0]        w_next_tgt;
    logic                    r_vld_out;
    logic [CUR_W-1:0]        r_tgt;
    logic                    r_sat;

    // Stage 1 conditioning: dead-band torque, clamped incline factor, cadence factor
    always_comb begin
        w_tq_diff = {1'b0, avg_torque} - {1'b0, TORQUE_MIN};
        w_tq_pos  = w_tq_diff[TQ_W] ? '0 : w_tq_diff[TQ_W-1:0];
        w_inc_s   = $signed(incline);
        if (w_inc_s > LP_INC_HI) begin
            w_inc_sat = 10'h1FF;
        end else if (w_inc_s < LP_INC_LO) begin
            w_inc_sat = 10'h200;
        end else begin
            w_inc_sat = w_inc_s[9:0];
        end
        w_inc_sum = {w_inc_sat[9], w_inc_sat} + 11'd256;
        if (w_inc_sum[10]) begin
            w_inc_fac = 9'd0;
        end else if (w_inc_sum[9]) begin
            w_inc_fac = 9'h1FF;
        end else begin
            w_inc_fac = w_inc_sum[8:0];
        end
        w_cad_fac = (cadence > 5'd1) ? ({1'b0, cadence} + 6'd32) : 6'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_np    <= 1'b0;
            r_s1_tq    <= '0;
            r_s1_incf  <= '0;
            r_s1_cadf  <= '0;
            r_s1_scale <= '0;
        end else begin
            r_s1_vld   <= vld_in;
            r_s1_np    <= not_pedaling;
            r_s1_tq    <= w_tq_pos;
            r_s1_incf  <= w_inc_fac;
            r_s1_cadf  <= w_cad_fac;
            r_s1_scale <= scale;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld <= 1'b0;
            r_s2_np  <= 1'b0;
            r_s2_pa  <= '0;
            r_s2_pb  <= '0;
        end else begin
            r_s2_vld <= r_s1_vld;
            r_s2_np  <= r_s1_np;
            r_s2_pa  <= PA_W'(r_s1_tq) * PA_W'(r_s1_incf);
            r_s2_pb  <= PB_W'(r_s1_cadf) * PB_W'(r_s1_scale);
        end
    end

    always_comb begin
        w_prod  = PROD_W'(r_s2_pa) * PROD_W'(r_s2_pb);
        w_q     = w_prod >> SHIFT;
        w_q_sat = (w_q > LP_Q_MAX);
        w_raw   = w_q_sat ? '1 : w_q[CUR_W-1:0];
    end

    // not_pedaling travels with its sample and only takes effect here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_vld <= 1'b0;
            r_s3_raw <= '0;
            r_s3_sat <= 1'b0;
        end else begin
            r_s3_vld <= r_s2_vld;
            r_s3_raw <= r_s2_np ? '0 : w_raw;
            r_s3_sat <= !r_s2_np && w_q_sat;
        end
    end

    always_comb begin
`ifdef DRIVE_SLEW_EN
        if (r_s3_raw > r_tgt) begin
            w_next_tgt = ((r_s3_raw - r_tgt) > SLEW_STEP) ? (r_tgt + SLEW_STEP) : r_s3_raw;
        end else if (r_s3_raw < r_tgt) begin
            w_next_tgt = ((r_tgt - r_s3_raw) > SLEW_STEP) ? (r_tgt - SLEW_STEP) : r_s3_raw;
        end else begin
            w_next_tgt = r_tgt;
        end
`else
        w_next_tgt = r_s3_raw;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_out <= 1'b0;
            r_tgt     <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_vld_out <= r_s3_vld;
            if (r_s3_vld) begin
                r_tgt <= w_next_tgt;
                r_sat <= r_s3_sat;
            end
        end
    end

    assign vld_out     = r_vld_out;
    assign target_curr = r_tgt;
    assign sat         = r_sat;

endmodule

// File: tb/tb_desired_drive_pipe.sv
// tb/tb_desired_drive_pipe.sv - directed self-checking bench for desired_drive_pipe
// Expected results follow the slew setting selected by DRIVE_SLEW_EN.
module tb_desired_drive_pipe;

    logic        clk;
    logic        rst_n;
    logic        vld_in;
    logic [11:0] avg_torque;
    logic [4:0]  cadence;
    logic [12:0] incline;
    logic [2:0]  scale;
    logic        not_pedaling;
    logic        vld_out;
    logic [11:0] target_curr;
    logic        sat;

    int n_chk;
    int n_fail;
    int n;
    logic        exp_v [0:511];
    logic [11:0] exp_t [0:511];
    logic        exp_s [0:511];
    logic [11:0] hold_t;
    logic        hold_s;

`ifdef DRIVE_SLEW_EN
    localparam logic [11:0] PRE_T  = 12'h100;
    localparam logic [11:0] POST_T = 12'h100;
`else
    localparam logic [11:0] PRE_T  = 12'hFFF;
    localparam logic [11:0] POST_T = 12'hA1A;
`endif

    desired_drive_pipe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vld_in       (vld_in),
        .avg_torque   (avg_torque),
        .cadence      (cadence),
        .incline      (incline),
        .scale        (scale),
        .not_pedaling (not_pedaling),
        .vld_out      (vld_out),
        .target_curr  (target_curr),
        .sat          (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    task automatic check_out();
        if (exp_v[n]) begin
            hold_t = exp_t[n];
            hold_s = exp_s[n];
        end
        check_val("vld_out", {31'd0, vld_out}, {31'd0, exp_v[n]});
        check_val("target_curr", {20'd0, target_curr}, {20'd0, hold_t});
        check_val("sat", {31'd0, sat}, {31'd0, hold_s});
    endtask

    // Called at a falling edge; sample is accepted on the next rising edge
    task automatic drive(input logic v, input logic [11:0] tq, input logic [4:0] cad,
                         input logic [12:0] inc, input logic [2:0] sc, input logic np,
                         input logic [11:0] et, input logic es);
        vld_in       = v;
        avg_torque   = tq;
        cadence      = cad;
        incline      = inc;
        scale        = sc;
        not_pedaling = np;
        exp_v[n+4]   = v;
        exp_t[n+4]   = et;
        exp_s[n+4]   = es;
        @(posedge clk);
        @(negedge clk);
        n++;
        check_out();
    endtask

    task automatic bubble(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, 12'h0, 5'h0, 13'h0, 3'd0, 1'b0, 12'h0, 1'b0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        n = 0;
        hold_t = 12'h0;
        hold_s = 1'b0;
        for (int i = 0; i < 512; i++) begin
            exp_v[i] = 1'b0;
            exp_t[i] = 12'h0;
            exp_s[i] = 1'b0;
        end
        rst_n = 1'b0;
        vld_in = 1'b0;
        avg_torque = 12'h0;
        cadence = 5'h0;
        incline = 13'h0;
        scale = 3'd0;
        not_pedaling = 1'b0;
        repeat (2) @(negedge clk);
        check_out();
        rst_n = 1'b1;

`ifdef DRIVE_SLEW_EN
        for (int i = 0; i < 14; i++)
            drive(1'b1, 12'h7E0, 5'h18, 13'h0000, 3'd7, 1'b0,
                  (i < 13) ? 12'((i + 1) * 256) : 12'hD66, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            int e;
            e = (12'hD66 > k * 256) ? (12'hD66 - k * 256) : 0;
            drive(1'b1, 12'h7E0, 5'h18, 13'h0000, 3'd7, 1'b1, 12'(e), 1'b0);
        end
        bubble(4);
`else
        drive(1'b1, 12'h800, 5'h10, 13'h0150, 3'd3, 1'b0, 12'hA1A, 1'b0);
        bubble(4);
        drive(1'b1, 12'h800, 5'h10, 13'h1F22, 3'd5, 1'b0, 12'h11E, 1'b0);
        drive(1'b1, 12'h360, 5'h10, 13'h1F22, 3'd5, 1'b0, 12'h000, 1'b0);
        drive(1'b1, 12'h7E0, 5'h18, 13'h0000, 3'd7, 1'b0, 12'hD66, 1'b0);
        drive(1'b1, 12'h7E0, 5'h18, 13'h0080, 3'd7, 1'b0, 12'hFFF, 1'b1);
        drive(1'b1, 12'h7E0, 5'h18, 13'h0080, 3'd7, 1'b1, 12'h000, 1'b0);
        drive(1'b1, 12'h800, 5'h02, 13'h0150, 3'd3, 1'b0, 12'h728, 1'b0);
        drive(1'b1, 12'h800, 5'h01, 13'h0150, 3'd3, 1'b0, 12'h000, 1'b0);
        drive(1'b1, 12'h800, 5'h10, 13'h1000, 3'd3, 1'b0, 12'h000, 1'b0);
        drive(1'b1, 12'h800, 5'h10, 13'h0150, 3'd0, 1'b0, 12'h000, 1'b0);
        bubble(4);
        drive(1'b1, 12'h800, 5'h10, 13'h0150, 3'd3, 1'b0, 12'hA1A, 1'b0);
        drive(1'b1, 12'h800, 5'h10, 13'h1F22, 3'd5, 1'b0, 12'h11E, 1'b0);
        bubble(1);
        drive(1'b1, 12'h7E0, 5'h18, 13'h0000, 3'd7, 1'b0, 12'hD66, 1'b0);
        bubble(4);
`endif

        drive(1'b1, 12'h7E0, 5'h18, 13'h0080, 3'd7, 1'b0, PRE_T, 1'b1);
        bubble(4);
        drive(1'b1, 12'h7E0, 5'h18, 13'h0000, 3'd7, 1'b0, 12'hD66, 1'b0);
        drive(1'b1, 12'h800, 5'h10, 13'h1F22, 3'd5, 1'b0, 12'h11E, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_vld_out", {31'd0, vld_out}, 32'd0);
        check_val("rst_target_curr", {20'd0, target_curr}, 32'd0);
        check_val("rst_sat", {31'd0, sat}, 32'd0);
        for (int i = n + 1; i <= n + 5; i++) exp_v[i] = 1'b0;
        hold_t = 12'h0;
        hold_s = 1'b0;
        vld_in = 1'b0;
        @(negedge clk);
        n++;
        check_out();
        rst_n = 1'b1;
        drive(1'b1, 12'h800, 5'h10, 13'h0150, 3'd3, 1'b0, POST_T, 1'b0);
        bubble(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
